// File: rtl/layer_composer_n.sv
// layer_composer_n: merges N_LAYERS layer line buffers and one sprite line buffer into the display pixel stream.
// Define LAYER_COMPOSER_COLLISION_EN to add sticky sprite/layer collision flags (collision_clr, collision).
module layer_composer_n #(
    parameter int N_LAYERS  = 2,
    parameter int ZW        = 2,
    parameter int LINE_W    = 640,
    parameter int LINE_H    = 480,
    parameter int FRAC_BITS = 7,
    parameter int HW        = 10,
    parameter int VW        = 9
) (
`ifdef LAYER_COMPOSER_COLLISION_EN
    input  logic                  collision_clr,
    output logic [N_LAYERS-1:0]   collision,
`endif
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  interlaced,
    input  logic [FRAC_BITS:0]    frac_x_incr,
    input  logic [FRAC_BITS:0]    frac_y_incr,
    input  logic [7:0]            border_color,
    input  logic [HW-1:0]         active_hstart,
    input  logic [HW-1:0]         active_hstop,
    input  logic [VW-1:0]         active_vstart,
    input  logic [VW-1:0]         active_vstop,
    input  logic [VW-1:0]         irqline,
    input  logic [N_LAYERS-1:0]   layer_enabled,
    input  logic                  sprites_enabled,
    output logic                  current_field,
    output logic                  line_irq,
    output logic [VW-1:0]         line_idx,
    output logic                  line_render_start,
    output logic [HW-1:0]         lb_rdidx,
    input  logic [8*N_LAYERS-1:0] layer_lb_rddata,
    input  logic [8+ZW-1:0]       sprite_lb_rddata,
    output logic                  sprite_lb_erase_start,
    input  logic                  display_next_frame,
    input  logic                  display_next_line,
    input  logic                  display_next_pixel,
    input  logic                  display_current_field,
    output logic [7:0]            display_data,
    output logic                  display_valid
);
    localparam int YSW = VW + FRAC_BITS;
    localparam int XSW = HW + FRAC_BITS;
    localparam logic [XSW-1:0] X_LIMIT = XSW'(LINE_W * (2 ** FRAC_BITS));
    localparam logic [VW:0]    Y_ONE   = {{VW{1'b0}}, 1'b1};
    localparam logic [VW:0]    Y_TWO   = {{(VW-1){1'b0}}, 2'b10};
    localparam logic [HW:0]    X_ONE   = {{HW{1'b0}}, 1'b1};
    localparam logic [HW:0]    X_TWO   = {{(HW-1){1'b0}}, 2'b10};

    logic [VW:0]    r_y_cnt;
    logic [VW:0]    r_y_cnt_d;
    logic [HW:0]    r_x_cnt;
    logic           r_current_field;
    logic           r_line_irq;
    logic           r_display_active;
    logic           r_line_d;
    logic           r_started;
    logic           r_frame_seen;
    logic           r_render_start;
    logic [YSW-1:0] r_y_scaled;
    logic [XSW-1:0] r_x_scaled;
    logic [7:0]     r_display_data;
    logic           r_display_valid;

    logic [HW-1:0]  w_x;
    logic           w_hactive;
    logic           w_vactive;
    logic           w_irq_hit;
    logic           w_first_line;
    logic           w_y_room;
    logic           w_x_room;
    logic [YSW-1:0] w_y_step;
    logic [XSW-1:0] w_x_step;
    logic [XSW:0]   w_x_sum;
    logic [7:0]     w_sprite_col;
    logic [ZW-1:0]  w_sprite_z;
    logic           w_sprite_on;
    logic [7:0]     w_pix;
    logic [7:0]     w_compose;

    assign w_x          = r_x_cnt[HW:1];
    assign w_hactive    = (w_x >= active_hstart) && (w_x < active_hstop);
    assign w_vactive    = (r_y_cnt_d >= {1'b0, active_vstart}) && (r_y_cnt_d < {1'b0, active_vstop});
    // Interlaced fields only ever see every other line, so the LSB is dropped from the compare.
    assign w_irq_hit    = interlaced ? (r_y_cnt[VW:1] == {1'b0, irqline[VW-1:1]})
                                     : (r_y_cnt == {1'b0, irqline});
    assign w_first_line = r_frame_seen && (r_y_cnt >= {1'b0, active_vstart});
    assign w_y_room     = r_y_scaled[YSW-1:FRAC_BITS] < VW'(LINE_H);
    assign w_x_room     = r_x_scaled[XSW-1:FRAC_BITS] < HW'(LINE_W);
    assign w_y_step     = interlaced ? YSW'({frac_y_incr, 1'b0}) : YSW'(frac_y_incr);
    assign w_x_step     = interlaced ? XSW'(frac_x_incr[FRAC_BITS:1]) : XSW'(frac_x_incr);
    assign w_x_sum      = {1'b0, r_x_scaled} + {1'b0, w_x_step};
    assign w_sprite_col = sprite_lb_rddata[7:0];
    assign w_sprite_z   = sprite_lb_rddata[8 +: ZW];
    assign w_sprite_on  = sprites_enabled && (w_sprite_col != 8'd0);

    // Raster bookkeeping: line/pixel counters, field, line interrupt and window flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_y_cnt          <= {(VW+1){1'b0}};
            r_y_cnt_d        <= {(VW+1){1'b0}};
            r_x_cnt          <= {(HW+1){1'b0}};
            r_current_field  <= 1'b0;
            r_line_irq       <= 1'b0;
            r_display_active <= 1'b0;
            r_line_d         <= 1'b0;
        end else begin
            if (display_next_frame) begin
                r_y_cnt         <= (interlaced && !display_current_field) ? Y_ONE : {(VW+1){1'b0}};
                r_current_field <= !display_current_field;
            end else if (display_next_line) begin
                r_y_cnt <= r_y_cnt + (interlaced ? Y_TWO : Y_ONE);
            end else begin
                r_y_cnt <= r_y_cnt;
            end
            if (display_next_line) begin
                r_y_cnt_d <= r_y_cnt;
                r_x_cnt   <= {(HW+1){1'b0}};
            end else if (display_next_pixel) begin
                r_x_cnt   <= r_x_cnt + (interlaced ? X_ONE : X_TWO);
            end else begin
                r_x_cnt   <= r_x_cnt;
            end
            r_line_irq       <= display_next_line && w_irq_hit;
            r_display_active <= w_hactive && w_vactive;
            r_line_d         <= display_next_line;
        end
    end

    // Scaled read positions; rendering is held off after reset until a frame boundary is seen.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_started      <= 1'b0;
            r_frame_seen   <= 1'b0;
            r_render_start <= 1'b0;
            r_y_scaled     <= {YSW{1'b0}};
            r_x_scaled     <= {XSW{1'b0}};
        end else begin
            if (display_next_frame) begin
                r_started      <= 1'b0;
                r_frame_seen   <= 1'b1;
                r_render_start <= 1'b0;
            end else if (r_line_d && !r_started) begin
                r_started      <= w_first_line;
                r_render_start <= w_first_line;
                if (w_first_line) begin
                    r_y_scaled <= (interlaced && (r_current_field ^ active_vstart[0]))
                                  ? YSW'(frac_y_incr) : {YSW{1'b0}};
                end
            end else if (r_line_d) begin
                r_render_start <= 1'b1;
                if (w_y_room && w_vactive) begin
                    r_y_scaled <= r_y_scaled + w_y_step;
                end
            end else begin
                r_render_start <= 1'b0;
            end
            if (display_next_line) begin
                r_x_scaled <= {XSW{1'b0}};
            end else if (display_next_pixel && w_hactive && w_x_room) begin
                r_x_scaled <= (w_x_sum > {1'b0, X_LIMIT}) ? X_LIMIT : w_x_sum[XSW-1:0];
            end
        end
    end

    // Painter's order: sprite slot z sits just below layer z-1; slot N_LAYERS+1 is on top.
    always_comb begin
        w_pix = 8'd0;
        for (int i = 0; i < N_LAYERS; i++) begin
            if (w_sprite_on && (w_sprite_z == ZW'(i + 1))) begin
                w_pix = w_sprite_col;
            end else begin
                w_pix = w_pix;
            end
            if (layer_enabled[i] && (layer_lb_rddata[8*i +: 8] != 8'd0)) begin
                w_pix = layer_lb_rddata[8*i +: 8];
            end else begin
                w_pix = w_pix;
            end
        end
        if (w_sprite_on && (w_sprite_z == ZW'(N_LAYERS + 1))) begin
            w_pix = w_sprite_col;
        end else begin
            w_pix = w_pix;
        end
        if (r_display_active) begin
            w_compose = w_pix;
        end else begin
            w_compose = border_color;
        end
    end

    // Output pixel register and its valid strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_display_data  <= 8'd0;
            r_display_valid <= 1'b0;
        end else begin
            r_display_data  <= w_compose;
            r_display_valid <= display_next_pixel;
        end
    end

`ifdef LAYER_COMPOSER_COLLISION_EN
    logic [N_LAYERS-1:0] r_collision;
    logic [N_LAYERS-1:0] w_coll_set;

    // A visible opaque sprite over an enabled opaque layer, inside the window.
    always_comb begin
        w_coll_set = {N_LAYERS{1'b0}};
        for (int i = 0; i < N_LAYERS; i++) begin
            w_coll_set[i] = r_display_active && (w_sprite_col != 8'd0) && (w_sprite_z != {ZW{1'b0}})
                            && layer_enabled[i] && (layer_lb_rddata[8*i +: 8] != 8'd0);
        end
    end

    // Sticky flags; a new hit beats a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_collision <= {N_LAYERS{1'b0}};
        end else begin
            r_collision <= w_coll_set | (collision_clr ? {N_LAYERS{1'b0}} : r_collision);
        end
    end

    assign collision = r_collision;
`endif

    assign current_field         = r_current_field;
    assign line_irq              = r_line_irq;
    assign line_idx              = r_y_scaled[YSW-1:FRAC_BITS];
    assign line_render_start     = r_render_start;
    assign lb_rdidx              = r_x_scaled[XSW-1:FRAC_BITS];
    assign sprite_lb_erase_start = (r_x_cnt == {HW'(LINE_W - 1), interlaced});
    assign display_data          = r_display_data;
    assign display_valid         = r_display_valid;

endmodule
